pipe_hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the in-order core. It replaces per-field stall muxing with per-pipeline-register hold and bubble enables. It detects load-use hazards with a configurable load latency, freezes the whole pipe on instruction- or data-memory stalls, and squashes younger stages on a resolved branch or jump redirect. It sits beside the decode stage and drives the enable/clear inputs of every pipeline register and the PC.

---
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: per-register hold/bubble enables, load-use stall, freeze, redirect squash.
// Latency: hold/bubble/pc_hold/lu_stall are combinational (same cycle); FSM and counters update on the next edge.
// Backpressure: fetch_stall | mem_stall freezes every pipeline register and the PC; nothing advances.
//
// Ports:
//   clk, rst (sync, active-low)            - clock and reset
//   fetch_stall, mem_stall                 - memory busy inputs, either one freezes the pipe
//   id_rs/id_rt (+_vld)                    - decode-stage source registers and read qualifiers
//   ex_memRead/ex_rd, mem_memRead/mem_rd   - in-flight loads and their destinations
//   redirect                               - taken branch/jump resolved at REDIRECT_STG
//   pc_hold, hold, bubble, lu_stall        - pipeline register controls
//   stall_cnt, flush_cnt                   - perf counters, present only with STALL_PERF_EN defined
//
// Optional feature macro: STALL_PERF_EN (counters implemented when defined, tied to 0 otherwise).

module pipe_hazard_ctrl #(
   parameter int NUM_STAGES   = 5,
   parameter int REG_AW       = 3,
   parameter int LOAD_LAT     = 1,
   parameter int REDIRECT_STG = 2,
   parameter int CNT_W        = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fetch_stall,
   input  logic                  mem_stall,
   input  logic [REG_AW-1:0]     id_rs,
   input  logic [REG_AW-1:0]     id_rt,
   input  logic                  id_rs_vld,
   input  logic                  id_rt_vld,
   input  logic                  ex_memRead,
   input  logic [REG_AW-1:0]     ex_rd,
   input  logic                  mem_memRead,
   input  logic [REG_AW-1:0]     mem_rd,
   input  logic                  redirect,
   output logic                  pc_hold,
   output logic [NUM_STAGES-2:0] hold,
   output logic [NUM_STAGES-2:0] bubble,
   output logic                  lu_stall,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam int NR = NUM_STAGES - 1;

   typedef enum logic [0:0] {
      RUN     = 1'b0,
      LUSTALL = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [1:0]      r_lu_cnt;
   logic [1:0]      w_lu_cnt_nxt;

   logic            w_frz;
   logic            w_ex_match;
   logic            w_mem_match;
   logic            w_hazard;
   logic [NR-1:0]   w_redir_mask;

   assign w_frz = fetch_stall | mem_stall;

   assign w_ex_match  = ex_memRead &
                        ((id_rs_vld & (id_rs == ex_rd)) | (id_rt_vld & (id_rt == ex_rd)));
   assign w_mem_match = mem_memRead &
                        ((id_rs_vld & (id_rs == mem_rd)) | (id_rt_vld & (id_rt == mem_rd)));

   // The memory-stage load only still matters when its data arrives two cycles late.
   assign w_hazard = w_ex_match | ((LOAD_LAT == 2) & w_mem_match);

   // Squash every register younger than the stage that resolved the redirect.
   always_comb begin
      w_redir_mask = '0;
      for (int i = 0; i < NR; i++) begin
         w_redir_mask[i] = (i < REDIRECT_STG);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state  <= RUN;
         r_lu_cnt <= 2'd0;
      end else begin
         r_state  <= w_state_nxt;
         r_lu_cnt <= w_lu_cnt_nxt;
      end
   end

   always_comb begin
      pc_hold      = 1'b0;
      hold         = '0;
      bubble       = '0;
      lu_stall     = 1'b0;
      w_state_nxt  = r_state;
      w_lu_cnt_nxt = r_lu_cnt;

      if (!rst) begin
         // Flush the whole pipe with NOPs and keep the PC while in reset.
         bubble  = '1;
         pc_hold = 1'b1;
      end else if (w_frz) begin
         // Freeze: state and remaining stall count are preserved.
         hold    = '1;
         pc_hold = 1'b1;
      end else if (redirect) begin
         // The dependent instruction is squashed, so any load-use stall is moot.
         bubble       = w_redir_mask;
         w_state_nxt  = RUN;
         w_lu_cnt_nxt = 2'd0;
      end else if (r_state == LUSTALL) begin
         pc_hold   = 1'b1;
         hold[0]   = 1'b1;
         bubble[1] = 1'b1;
         lu_stall  = 1'b1;
         if (r_lu_cnt <= 2'd1) begin
            w_state_nxt  = RUN;
            w_lu_cnt_nxt = 2'd0;
         end else begin
            w_lu_cnt_nxt = r_lu_cnt - 2'd1;
         end
      end else if (w_hazard) begin
         // Hold IF/ID and the PC, insert a NOP into ID/EX.
         pc_hold   = 1'b1;
         hold[0]   = 1'b1;
         bubble[1] = 1'b1;
         lu_stall  = 1'b1;
         if (LOAD_LAT > 1) begin
            w_state_nxt  = LUSTALL;
            w_lu_cnt_nxt = 2'(LOAD_LAT - 1);
         end
      end
   end

`ifdef STALL_PERF_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;
   logic             w_redir_acc;

   assign w_redir_acc = redirect & ~w_frz;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (pc_hold && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
         end
         if (w_redir_acc && (r_flush_cnt != '1)) begin
            r_flush_cnt <= r_flush_cnt + CNT_W'(1);
         end
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=2, CNT_W=4)
// share one stimulus; each scenario task checks the instance relevant to it.
// Outputs are packed as {pc_hold, hold[3:0], bubble[3:0], lu_stall} for comparison.

module tb_pipe_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       fetch_stall, mem_stall;
   logic [2:0] id_rs, id_rt, ex_rd, mem_rd;
   logic       id_rs_vld, id_rt_vld, ex_memRead, mem_memRead, redirect;

   int checks = 0;
   int errors = 0;

`ifdef STALL_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   localparam logic [9:0] O_ZERO = 10'b0_0000_0000_0;
   localparam logic [9:0] O_LUS  = 10'b1_0001_0010_1;
   localparam logic [9:0] O_FRZ  = 10'b1_1111_0000_0;
   localparam logic [9:0] O_RST  = 10'b1_0000_1111_0;
   localparam logic [9:0] O_RED  = 10'b0_0000_0011_0;

   logic        a_pc, b_pc, c_pc;
   logic [3:0]  a_hold, a_bub, b_hold, b_bub, c_hold, c_bub;
   logic        a_lu, b_lu, c_lu;
   logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
   logic [3:0]  c_scnt, c_fcnt;
   logic [9:0]  a_o, b_o;

   assign a_o = {a_pc, a_hold, a_bub, a_lu};
   assign b_o = {b_pc, b_hold, b_bub, b_lu};

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.LOAD_LAT(1)) u_l1 (
      .clk(clk), .rst(rst), .fetch_stall(fetch_stall), .mem_stall(mem_stall),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
      .ex_memRead(ex_memRead), .ex_rd(ex_rd), .mem_memRead(mem_memRead), .mem_rd(mem_rd),
      .redirect(redirect), .pc_hold(a_pc), .hold(a_hold), .bubble(a_bub), .lu_stall(a_lu),
      .stall_cnt(a_scnt), .flush_cnt(a_fcnt));

   pipe_hazard_ctrl #(.LOAD_LAT(2)) u_l2 (
      .clk(clk), .rst(rst), .fetch_stall(fetch_stall), .mem_stall(mem_stall),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
      .ex_memRead(ex_memRead), .ex_rd(ex_rd), .mem_memRead(mem_memRead), .mem_rd(mem_rd),
      .redirect(redirect), .pc_hold(b_pc), .hold(b_hold), .bubble(b_bub), .lu_stall(b_lu),
      .stall_cnt(b_scnt), .flush_cnt(b_fcnt));

   pipe_hazard_ctrl #(.CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .fetch_stall(fetch_stall), .mem_stall(mem_stall),
      .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
      .ex_memRead(ex_memRead), .ex_rd(ex_rd), .mem_memRead(mem_memRead), .mem_rd(mem_rd),
      .redirect(redirect), .pc_hold(c_pc), .hold(c_hold), .bubble(c_bub), .lu_stall(c_lu),
      .stall_cnt(c_scnt), .flush_cnt(c_fcnt));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      fetch_stall = 1'b0; mem_stall = 1'b0; redirect = 1'b0;
      id_rs = 3'd0; id_rt = 3'd0; id_rs_vld = 1'b0; id_rt_vld = 1'b0;
      ex_memRead = 1'b0; ex_rd = 3'd0; mem_memRead = 1'b0; mem_rd = 3'd0;
   endtask

   task automatic set_hazard();
      ex_memRead = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_vld = 1'b1;
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      idle();
      rst = 1'b0;
      tick();
      #1;
      checks++;
      if (a_o !== O_RST) begin errors++; $display("FAIL reset_outputs: got %b expected %b", a_o, O_RST); end
      rst = 1'b1;
      #1;
      checks++;
      if (a_o !== O_ZERO) begin errors++; $display("FAIL reset_release_outputs: got %b expected %b", a_o, O_ZERO); end
      checks++;
      if (a_scnt !== 16'd0 || a_fcnt !== 16'd0) begin
         errors++; $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0/0", a_scnt, a_fcnt);
      end
   endtask

   task automatic test_load_use_l1();
      do_reset();
      set_hazard();
      #1;
      checks++;
      if (a_o !== O_LUS) begin errors++; $display("FAIL lu_l1_stall: got %b expected %b", a_o, O_LUS); end
      tick();
      idle();
      #1;
      checks++;
      if (a_o !== O_ZERO) begin errors++; $display("FAIL lu_l1_release: got %b expected %b", a_o, O_ZERO); end
      checks++;
      if (a_scnt !== (PERF ? 16'd1 : 16'd0)) begin
         errors++; $display("FAIL lu_l1_stall_cnt: got %0d expected %0d", a_scnt, PERF ? 1 : 0);
      end
      // rt path also detects the hazard
      ex_memRead = 1'b1; ex_rd = 3'd6; id_rt = 3'd6; id_rt_vld = 1'b1;
      #1;
      checks++;
      if (a_o !== O_LUS) begin errors++; $display("FAIL lu_l1_rt: got %b expected %b", a_o, O_LUS); end
      idle();
   endtask

   task automatic test_load_use_l2();
      do_reset();
      set_hazard();
      #1;
      checks++;
      if (b_o !== O_LUS) begin errors++; $display("FAIL lu_l2_c0: got %b expected %b", b_o, O_LUS); end
      tick();
      idle();
      #1;
      checks++;
      if (b_o !== O_LUS) begin errors++; $display("FAIL lu_l2_c1: got %b expected %b", b_o, O_LUS); end
      tick();
      #1;
      checks++;
      if (b_o !== O_ZERO) begin errors++; $display("FAIL lu_l2_c2: got %b expected %b", b_o, O_ZERO); end
      // memory-stage load match also triggers the stall
      mem_memRead = 1'b1; mem_rd = 3'd4; id_rt = 3'd4; id_rt_vld = 1'b1;
      #1;
      checks++;
      if (b_o !== O_LUS) begin errors++; $display("FAIL lu_l2_memstage: got %b expected %b", b_o, O_LUS); end
      checks++;
      if (a_o !== O_ZERO) begin errors++; $display("FAIL lu_l1_ignores_mem: got %b expected %b", a_o, O_ZERO); end
      idle();
   endtask

   task automatic test_freeze_lustall();
      do_reset();
      set_hazard();
      tick();                       // cycle 0 stalls, FSM enters LUSTALL
      idle();
      mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (b_o !== O_FRZ) begin errors++; $display("FAIL frz_l2_c%0d: got %b expected %b", i + 1, b_o, O_FRZ); end
         tick();
      end
      mem_stall = 1'b0;
      #1;
      checks++;
      if (b_o !== O_LUS) begin errors++; $display("FAIL frz_l2_final: got %b expected %b", b_o, O_LUS); end
      tick();
      #1;
      checks++;
      if (b_o !== O_ZERO) begin errors++; $display("FAIL frz_l2_done: got %b expected %b", b_o, O_ZERO); end
      checks++;
      if (b_scnt !== (PERF ? 16'd5 : 16'd0)) begin
         errors++; $display("FAIL frz_l2_stall_cnt: got %0d expected %0d", b_scnt, PERF ? 5 : 0);
      end
   endtask

   task automatic test_redirect();
      do_reset();
      set_hazard();
      redirect = 1'b1;
      #1;
      checks++;
      if (b_o !== O_RED) begin errors++; $display("FAIL redir_hazard_l2: got %b expected %b", b_o, O_RED); end
      checks++;
      if (a_o !== O_RED) begin errors++; $display("FAIL redir_hazard_l1: got %b expected %b", a_o, O_RED); end
      tick();
      idle();
      #1;
      checks++;
      if (b_o !== O_ZERO) begin errors++; $display("FAIL redir_stays_run: got %b expected %b", b_o, O_ZERO); end
      checks++;
      if (a_fcnt !== (PERF ? 16'd1 : 16'd0)) begin
         errors++; $display("FAIL redir_flush_cnt: got %0d expected %0d", a_fcnt, PERF ? 1 : 0);
      end
      // redirect held through a freeze is taken once, after the freeze
      redirect = 1'b1; fetch_stall = 1'b1;
      #1;
      checks++;
      if (a_o !== O_FRZ) begin errors++; $display("FAIL redir_frozen: got %b expected %b", a_o, O_FRZ); end
      tick();
      fetch_stall = 1'b0;
      #1;
      checks++;
      if (a_o !== O_RED) begin errors++; $display("FAIL redir_after_frz: got %b expected %b", a_o, O_RED); end
      tick();
      idle();
      #1;
      checks++;
      if (a_fcnt !== (PERF ? 16'd2 : 16'd0)) begin
         errors++; $display("FAIL redir_flush_cnt2: got %0d expected %0d", a_fcnt, PERF ? 2 : 0);
      end
   endtask

   task automatic test_src_mismatch();
      do_reset();
      ex_memRead = 1'b1; ex_rd = 3'd3; id_rs = 3'd3; id_rs_vld = 1'b0; id_rt = 3'd5; id_rt_vld = 1'b1;
      #1;
      checks++;
      if (a_o !== O_ZERO) begin errors++; $display("FAIL src_mismatch: got %b expected %b", a_o, O_ZERO); end
      idle();
   endtask

   task automatic test_reset_mid_lustall();
      do_reset();
      set_hazard();
      tick();                       // u_l2 now in LUSTALL
      idle();
      rst = 1'b0;
      #1;
      checks++;
      if (b_o !== O_RST) begin errors++; $display("FAIL rst_mid_lus: got %b expected %b", b_o, O_RST); end
      tick();
      rst = 1'b1;
      #1;
      checks++;
      if (b_o !== O_ZERO) begin errors++; $display("FAIL rst_no_residual: got %b expected %b", b_o, O_ZERO); end
      checks++;
      if (b_scnt !== 16'd0 || b_fcnt !== 16'd0) begin
         errors++; $display("FAIL rst_mid_counters: got stall=%0d flush=%0d expected 0/0", b_scnt, b_fcnt);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      fetch_stall = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      idle();
      #1;
      checks++;
      if (c_scnt !== (PERF ? 4'd15 : 4'd0)) begin
         errors++; $display("FAIL sat_cnt_w4: got %0d expected %0d", c_scnt, PERF ? 15 : 0);
      end
      checks++;
      if (a_scnt !== (PERF ? 16'd20 : 16'd0)) begin
         errors++; $display("FAIL sat_cnt_w16: got %0d expected %0d", a_scnt, PERF ? 20 : 0);
      end
   endtask

   initial begin
      rst = 1'b0;
      idle();
      test_reset();
      test_load_use_l1();
      test_load_use_l2();
      test_freeze_lustall();
      test_redirect();
      test_src_mismatch();
      test_reset_mid_lustall();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
